// File: rtl/register_file_16x32_if.sv
// Write-back / operand bus between the datapath and the 16x32 register file.
// The master drives write-back and read selects; the slave returns operands and PC.
interface register_file_16x32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] rw;
    logic [3:0]       rd_sel;
    logic             rf_le;
    logic             pc_le;
    logic [3:0]       ra_sel;
    logic [3:0]       rb_sel;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] pc;

    modport master (
        output rw, rd_sel, rf_le, pc_le, ra_sel, rb_sel,
        input  pa, pb, pc
    );

    modport slave (
        input  rw, rd_sel, rf_le, pc_le, ra_sel, rb_sel,
        output pa, pb, pc
    );
endinterface

// File: rtl/register_file_16x32.sv
// 16-entry architectural register file: one write port with read bypass,
// two combinational read ports, and R15 doubling as an auto-incrementing PC.
module register_file_16x32 #(
    parameter int             WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(4),
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic                  clk,
    input  logic                  clr,
    register_file_16x32_if.slave  bus
);
    localparam int NREG = 16;
    localparam int PC_IDX = 15;

    logic [NREG-1:0][WIDTH-1:0] regs;
    logic [NREG-1:0]            wr_hit;
    logic                       byp_a;
    logic                       byp_b;

    always_comb begin
        wr_hit = '0;
        if (bus.rf_le)
            wr_hit[bus.rd_sel] = 1'b1;
    end

    // An explicit write to R15 is a branch and wins over the increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == PC_IDX) ? PC_RESET : '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_hit[i])
                    regs[i] <= bus.rw;
                else if (i == PC_IDX && bus.pc_le)
                    regs[i] <= regs[i] + PC_STEP;
            end
        end
    end

    // Write-to-read forwarding; a pending PC increment is deliberately not forwarded.
    assign byp_a = bus.rf_le && !clr && (bus.ra_sel == bus.rd_sel);
    assign byp_b = bus.rf_le && !clr && (bus.rb_sel == bus.rd_sel);

    assign bus.pa = byp_a ? bus.rw : regs[bus.ra_sel];
    assign bus.pb = byp_b ? bus.rw : regs[bus.rb_sel];
    assign bus.pc = regs[PC_IDX];
endmodule
